// File: rtl/decider_scan.sv
// Decision engine: scans the variable-assignment table for the first unassigned
// variable and offers it to the decision stack with positive polarity.
module decider_scan #(
    parameter int MAX_VARS      = 8,
    parameter int MAX_VARS_BITS = $clog2(MAX_VARS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [MAX_VARS_BITS-1:0] start_idx,
    input  logic                     abort,
    output logic                     mem_rd_en,
    output logic [MAX_VARS_BITS-1:0] mem_rd_idx,
    input  logic                     mem_rd_assigned,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [MAX_VARS_BITS-1:0] dec_idx,
    output logic                     dec_val,
    output logic                     push,
    output logic                     busy,
    output logic                     all_assigned
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DECIDE,
        S_SAT
    } state_t;

    localparam logic [MAX_VARS_BITS-1:0] LAST_IDX = MAX_VARS_BITS'(MAX_VARS - 1);
    localparam logic [MAX_VARS_BITS:0]   NUM_VARS = (MAX_VARS_BITS + 1)'(MAX_VARS);

    state_t                   state_q, state_d;
    logic [MAX_VARS_BITS-1:0] issue_idx_q, issue_idx_d;
    logic [MAX_VARS_BITS-1:0] chk_idx_q, chk_idx_d;
    logic [MAX_VARS_BITS-1:0] dec_idx_q, dec_idx_d;
    logic                     chk_valid_q, chk_valid_d;
    logic                     issue_done_q, issue_done_d;
    logic                     rd_en;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            issue_idx_q  <= '0;
            chk_idx_q    <= '0;
            dec_idx_q    <= '0;
            chk_valid_q  <= 1'b0;
            issue_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_idx_q  <= issue_idx_d;
            chk_idx_q    <= chk_idx_d;
            dec_idx_q    <= dec_idx_d;
            chk_valid_q  <= chk_valid_d;
            issue_done_q <= issue_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        issue_idx_d  = issue_idx_q;
        chk_idx_d    = chk_idx_q;
        dec_idx_d    = dec_idx_q;
        chk_valid_d  = chk_valid_q;
        issue_done_d = issue_done_q;
        rd_en        = (state_q == S_SCAN) && !issue_done_q;

        unique case (state_q)
            S_IDLE, S_SAT: begin
                if (start) begin
                    issue_idx_d  = start_idx;
                    chk_valid_d  = 1'b0;
                    issue_done_d = 1'b0;
                    if ({1'b0, start_idx} >= NUM_VARS)
                        state_d = S_SAT;
                    else
                        state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                chk_valid_d = rd_en;
                chk_idx_d   = issue_idx_q;
                if (rd_en) begin
                    if (issue_idx_q == LAST_IDX)
                        issue_done_d = 1'b1;
                    else
                        issue_idx_d = issue_idx_q + 1'b1;
                end
                // Result of the read issued alongside a hit is simply dropped.
                if (chk_valid_q) begin
                    if (!mem_rd_assigned) begin
                        dec_idx_d   = chk_idx_q;
                        chk_valid_d = 1'b0;
                        state_d     = S_DECIDE;
                    end else if (chk_idx_q == LAST_IDX) begin
                        chk_valid_d = 1'b0;
                        state_d     = S_SAT;
                    end
                end
            end
            S_DECIDE: begin
                if (dec_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            chk_valid_d = 1'b0;
        end
    end

    assign mem_rd_en    = rd_en;
    assign mem_rd_idx   = rd_en ? issue_idx_q : '0;
    assign dec_valid    = (state_q == S_DECIDE);
    assign dec_idx      = dec_idx_q;
    assign dec_val      = (state_q == S_DECIDE);
    assign push         = (state_q == S_DECIDE) && dec_ready && !abort;
    assign busy         = (state_q == S_SCAN) || (state_q == S_DECIDE);
    assign all_assigned = (state_q == S_SAT);

endmodule

// File: tb/tb_decider_scan.sv
// Directed bench for decider_scan with an 8-entry assignment table
// that answers reads one cycle after mem_rd_en.
module tb_decider_scan;

    localparam int NV = 8;
    localparam int NB = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [NB-1:0] start_idx;
    logic          abort;
    logic          mem_rd_en;
    logic [NB-1:0] mem_rd_idx;
    logic          mem_rd_assigned;
    logic          dec_valid;
    logic          dec_ready;
    logic [NB-1:0] dec_idx;
    logic          dec_val;
    logic          push;
    logic          busy;
    logic          all_assigned;

    logic [NV-1:0] tbl;
    int            push_cnt = 0;
    int            n_pass = 0;
    int            n_total = 0;

    always #5 clock = ~clock;

    decider_scan #(.MAX_VARS(NV), .MAX_VARS_BITS(NB)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .start_idx      (start_idx),
        .abort          (abort),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_idx     (mem_rd_idx),
        .mem_rd_assigned(mem_rd_assigned),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_idx        (dec_idx),
        .dec_val        (dec_val),
        .push           (push),
        .busy           (busy),
        .all_assigned   (all_assigned)
    );

    always @(posedge clock) begin
        if (mem_rd_en)
            mem_rd_assigned <= tbl[mem_rd_idx];
    end

    always @(posedge clock) begin
        if (push)
            push_cnt = push_cnt + 1;
    end

    task automatic kick(input logic [NB-1:0] idx);
        @(negedge clock);
        start     = 1'b1;
        start_idx = idx;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic test_reset();
        int p0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_total++;
        if ({mem_rd_en, dec_valid, dec_val, push, busy, all_assigned} !== 6'b0)
            $display("FAIL por_outputs got=%b want=000000",
                     {mem_rd_en, dec_valid, dec_val, push, busy, all_assigned});
        else n_pass++;
        reset = 1'b1;
        tbl   = 8'hFF;
        kick(3'd0);
        @(negedge clock);
        n_total++;
        if (busy !== 1'b1) $display("FAIL mid_scan_busy got=%b want=1", busy);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_total++;
        if ({mem_rd_en, mem_rd_idx, dec_valid, dec_idx, dec_val,
             push, busy, all_assigned} !== 12'b0)
            $display("FAIL reset_outputs got=%b want=0",
                     {mem_rd_en, mem_rd_idx, dec_valid, dec_idx, dec_val,
                      push, busy, all_assigned});
        else n_pass++;
        reset = 1'b1;
        dec_ready = 1'b1;
        p0 = push_cnt;
        repeat (12) @(negedge clock);
        n_total++;
        if ({busy, all_assigned, mem_rd_en} !== 3'b000 || push_cnt !== p0)
            $display("FAIL reset_idle got=%b pushes=%0d want=000 pushes=%0d",
                     {busy, all_assigned, mem_rd_en}, push_cnt, p0);
        else n_pass++;
        dec_ready = 1'b0;
    endtask

    task automatic test_decide();
        int p0;
        tbl       = 8'b0000_0111;
        dec_ready = 1'b1;
        p0        = push_cnt;
        kick(3'd0);
        for (int j = 0; j < 4; j++) begin
            n_total++;
            if (mem_rd_en !== 1'b1 || mem_rd_idx !== NB'(j))
                $display("FAIL read_seq j=%0d got en=%b idx=%0d want en=1 idx=%0d",
                         j, mem_rd_en, mem_rd_idx, j);
            else n_pass++;
            @(negedge clock);
        end
        n_total++;
        if (dec_valid !== 1'b0) $display("FAIL early_valid got=%b want=0", dec_valid);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (dec_valid !== 1'b1 || dec_idx !== 3'd3 || dec_val !== 1'b1 ||
            push !== 1'b1 || mem_rd_en !== 1'b0)
            $display("FAIL decide got v=%b idx=%0d val=%b push=%b rd=%b want 1 3 1 1 0",
                     dec_valid, dec_idx, dec_val, push, mem_rd_en);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (dec_valid !== 1'b0 || busy !== 1'b0 || push_cnt !== p0 + 1)
            $display("FAIL after_push got v=%b busy=%b pushes=%0d want 0 0 %0d",
                     dec_valid, busy, push_cnt - p0, 1);
        else n_pass++;
        dec_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int p0;
        tbl       = 8'b0000_0111;
        dec_ready = 1'b0;
        p0        = push_cnt;
        kick(3'd0);
        repeat (5) @(negedge clock);
        for (int c = 0; c < 5; c++) begin
            n_total++;
            if (dec_valid !== 1'b1 || dec_idx !== 3'd3 || push !== 1'b0)
                $display("FAIL hold c=%0d got v=%b idx=%0d push=%b want 1 3 0",
                         c, dec_valid, dec_idx, push);
            else n_pass++;
            if (c < 4) @(negedge clock);
        end
        dec_ready = 1'b1;
        #1;
        n_total++;
        if (push !== 1'b1) $display("FAIL accept_push got=%b want=1", push);
        else n_pass++;
        @(negedge clock);
        dec_ready = 1'b0;
        n_total++;
        if (busy !== 1'b0 || dec_valid !== 1'b0 || push_cnt !== p0 + 1)
            $display("FAIL accept_idle got busy=%b v=%b pushes=%0d want 0 0 1",
                     busy, dec_valid, push_cnt - p0);
        else n_pass++;
    endtask

    task automatic test_all_assigned();
        int p0;
        logic [NB-1:0] exp_idx [3];
        exp_idx = '{3'd5, 3'd6, 3'd7};
        tbl       = 8'hFF;
        dec_ready = 1'b1;
        p0        = push_cnt;
        kick(3'd5);
        for (int j = 0; j < 3; j++) begin
            n_total++;
            if (mem_rd_en !== 1'b1 || mem_rd_idx !== exp_idx[j])
                $display("FAIL sat_reads j=%0d got en=%b idx=%0d want en=1 idx=%0d",
                         j, mem_rd_en, mem_rd_idx, exp_idx[j]);
            else n_pass++;
            @(negedge clock);
        end
        n_total++;
        if (mem_rd_en !== 1'b0 || all_assigned !== 1'b0)
            $display("FAIL sat_tail got rd=%b sat=%b want 0 0", mem_rd_en, all_assigned);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (all_assigned !== 1'b1 || busy !== 1'b0)
            $display("FAIL sat_enter got sat=%b busy=%b want 1 0", all_assigned, busy);
        else n_pass++;
        repeat (6) @(negedge clock);
        n_total++;
        if (all_assigned !== 1'b1 || push_cnt !== p0)
            $display("FAIL sat_hold got sat=%b pushes=%0d want 1 0",
                     all_assigned, push_cnt - p0);
        else n_pass++;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_total++;
        if (all_assigned !== 1'b0 || busy !== 1'b0)
            $display("FAIL sat_abort got sat=%b busy=%b want 0 0", all_assigned, busy);
        else n_pass++;
        dec_ready = 1'b0;
    endtask

    task automatic test_abort();
        int p0;
        tbl       = 8'b1011_1111;
        dec_ready = 1'b0;
        p0        = push_cnt;
        kick(3'd6);
        @(negedge clock);
        @(negedge clock);
        n_total++;
        if (dec_valid !== 1'b1 || dec_idx !== 3'd6)
            $display("FAIL abort_pre got v=%b idx=%0d want 1 6", dec_valid, dec_idx);
        else n_pass++;
        dec_ready = 1'b1;
        abort     = 1'b1;
        #1;
        n_total++;
        if (push !== 1'b0) $display("FAIL abort_push got=%b want=0", push);
        else n_pass++;
        @(negedge clock);
        abort     = 1'b0;
        n_total++;
        if (busy !== 1'b0 || dec_valid !== 1'b0 || push_cnt !== p0)
            $display("FAIL abort_idle got busy=%b v=%b pushes=%0d want 0 0 0",
                     busy, dec_valid, push_cnt - p0);
        else n_pass++;
        repeat (3) @(negedge clock);
        n_total++;
        if (push_cnt !== p0) $display("FAIL abort_nopush got=%0d want=0", push_cnt - p0);
        else n_pass++;
        dec_ready = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int p0;
        tbl       = 8'b0000_0111;
        dec_ready = 1'b0;
        p0        = push_cnt;
        kick(3'd0);
        start     = 1'b1;
        start_idx = 3'd5;
        @(negedge clock);
        start     = 1'b0;
        repeat (4) @(negedge clock);
        n_total++;
        if (dec_valid !== 1'b1 || dec_idx !== 3'd3)
            $display("FAIL busy_start got v=%b idx=%0d want 1 3", dec_valid, dec_idx);
        else n_pass++;
        start     = 1'b1;
        start_idx = 3'd0;
        @(negedge clock);
        start     = 1'b0;
        n_total++;
        if (dec_valid !== 1'b1 || dec_idx !== 3'd3 || mem_rd_en !== 1'b0)
            $display("FAIL decide_start got v=%b idx=%0d rd=%b want 1 3 0",
                     dec_valid, dec_idx, mem_rd_en);
        else n_pass++;
        dec_ready = 1'b1;
        @(negedge clock);
        dec_ready = 1'b0;
        n_total++;
        if (push_cnt !== p0 + 1 || busy !== 1'b0)
            $display("FAIL busy_push got pushes=%0d busy=%b want 1 0",
                     push_cnt - p0, busy);
        else n_pass++;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        start_idx = '0;
        abort     = 1'b0;
        dec_ready = 1'b0;
        tbl       = '0;
        test_reset();
        test_decide();
        test_backpressure();
        test_all_assigned();
        test_abort();
        test_start_while_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decider_scan.md
Name: decider_scan

Overview:
- Decision engine feeding the decision stack.
- On request from the control FSM, scans the variable-assignment table from a given start index. It finds the first unassigned variable and issues it as a decision (positive polarity first).
- On handshake acceptance it pulses the push strobe into the decision stack.
- When no unassigned variable remains, it reports satisfiable (all assigned).

Parameters:
- MAX_VARS, from sysdefs.svh: number of variables, indices 0..MAX_VARS-1.
- MAX_VARS_BITS, from sysdefs.svh: index width, equal to clog2(MAX_VARS).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous active-low reset (asserted when 0).
- start  input  1  begin a scan; sampled only in IDLE or SAT.
- start_idx  input  MAX_VARS_BITS  first index to examine; 0 for a fresh search, or the resume index supplied by control after a pop.
- abort  input  1  flush to IDLE (conflict/backtrack).
- mem_rd_en  output  1  read strobe to the variable-state table.
- mem_rd_idx  output  MAX_VARS_BITS  read address.
- mem_rd_assigned  input  1  1 = variable assigned; valid exactly 1 cycle after mem_rd_en.
- dec_valid  output  1  decision available.
- dec_ready  input  1  consumer accepts decision.
- dec_idx  output  MAX_VARS_BITS  decided variable index.
- dec_val  output  1  decided polarity, always 1.
- push  output  1  decision-stack push strobe (carries dec_idx).
- busy  output  1  high in SCAN or DECIDE.
- all_assigned  output  1  high in SAT.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE, all outputs 0, internal issue_idx/chk_idx/chk_valid/issue_done cleared. Reset mid-scan discards in-flight reads.
- States: IDLE, SCAN, DECIDE, SAT.
- IDLE: start -> issue_idx<=start_idx, chk_valid<=0, issue_done<=0, -> SCAN. If start_idx>=MAX_VARS -> SAT directly.
- SCAN, issue side (pipelined, one read per cycle):
  - While !issue_done: mem_rd_en=1, mem_rd_idx=issue_idx.
  - Next cycle: chk_idx<=issue_idx, chk_valid<=1.
  - If issue_idx==MAX_VARS-1, set issue_done (no wrap-around); otherwise issue_idx increments.
- SCAN, check side, when chk_valid:
  - mem_rd_assigned==0 -> dec_idx<=chk_idx, -> DECIDE. The read issued in the same cycle is discarded; mem_rd_en is 0 in DECIDE.
  - mem_rd_assigned==1 and chk_idx==MAX_VARS-1 -> SAT.
- DECIDE:
  - dec_valid=1; dec_idx/dec_val stable until accepted.
  - dec_valid&&dec_ready -> push=1 for that single cycle (combinational with the handshake), -> IDLE.
  - dec_valid never drops without acceptance, except on abort or reset.
- SAT: all_assigned=1 held. start -> behaves as from IDLE; abort -> IDLE.
- abort has priority over start and dec_ready in every state:
  - Next state is IDLE.
  - No push, even if dec_ready is high that cycle.
  - Pending read result is ignored.
- start in SCAN/DECIDE is ignored.
- push only ever asserts in DECIDE; at most one push per start.
- Latency, start sampled at edge T with k assigned variables before the first unassigned one:
  - mem_rd_en first high in cycle T+1.
  - DECIDE entered at edge T+2+k; dec_valid high in cycle T+2+k.
  - Scan from index s with all of s..MAX_VARS-1 assigned: all_assigned high at cycle T+1+(MAX_VARS-s).
- Index arithmetic: MAX_VARS_BITS unsigned; the end-of-range compare is on chk_idx, never on an overflowed counter.

Test Plan (MAX_VARS=8; the bench models the table with 1-cycle read latency):
- Reset low 2 cycles mid-SCAN -> all outputs 0, state IDLE; no push afterwards without a new start.
- Table assigned={1,1,1,0,...}, start_idx=0, dec_ready=1:
  - reads idx 0,1,2,3 on consecutive cycles;
  - dec_valid with dec_idx=3, dec_val=1 four cycles after the first read;
  - push one cycle.
- Same table, dec_ready held 0 for 5 cycles -> dec_valid/dec_idx=3 stable 5 cycles, push 0; dec_ready=1 -> single push, then IDLE.
- All assigned, start_idx=5 -> reads 5,6,7; all_assigned=1 and stays until start/abort; push never asserted.
- start_idx=6, var 6 unassigned, abort asserted in the same cycle as dec_ready -> no push; IDLE next cycle.
- start asserted while busy -> ignored; scan result unchanged (dec_idx matches the original start).
